// File: rtl/jedro_1_sig_pkg.sv
// jedro_1_sig_pkg: shared types for the signature monitor.
// Holds the FSM state enum and the reserved-cell offsets.
package jedro_1_sig_pkg;

  typedef enum logic [2:0] {
    S_RUN,
    S_REQ,
    S_RSP,
    S_EMIT,
    S_DONE
  } sig_state_e;

  localparam int unsigned CELL_START = 1;
  localparam int unsigned CELL_END   = 2;
  localparam int unsigned CELL_HALT  = 3;

endpackage

// File: rtl/jedro_1_sig_monitor.sv
// jedro_1_sig_monitor: snoops the signature range and halt, then streams words.
// Optional run-cycle watchdog: JEDRO_1_SIG_MONITOR_TIMEOUT_EN.
module jedro_1_sig_monitor
  import jedro_1_sig_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned MEM_SIZE_WORDS = 1 << 19,
  parameter int unsigned TIMEOUT        = 1000000
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic [ADDR_WIDTH-1:0]   snp_req_addr_i,
  input  logic [DATA_WIDTH-1:0]   snp_req_data_i,
  input  logic [DATA_WIDTH/8-1:0] snp_req_strobe_i,
  input  logic                    snp_req_write_i,
  input  logic                    snp_req_valid_i,
  input  logic                    snp_req_ready_i,
  output logic [ADDR_WIDTH-1:0]   rd_req_addr_o,
  output logic                    rd_req_valid_o,
  input  logic                    rd_req_ready_i,
  input  logic [DATA_WIDTH-1:0]   rd_rsp_data_i,
  input  logic                    rd_rsp_valid_i,
  output logic                    rd_rsp_ready_o,
  output logic [DATA_WIDTH-1:0]   sig_data_o,
  output logic                    sig_valid_o,
  output logic                    sig_last_o,
  input  logic                    sig_ready_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    timeout_o
);

  localparam int unsigned BW  = DATA_WIDTH / 8;
  localparam int unsigned OFF = (BW > 1) ? $clog2(BW) : 0;

  localparam logic [ADDR_WIDTH-1:0] IDX_START =
    ADDR_WIDTH'(MEM_SIZE_WORDS - CELL_START);
  localparam logic [ADDR_WIDTH-1:0] IDX_END =
    ADDR_WIDTH'(MEM_SIZE_WORDS - CELL_END);
  localparam logic [ADDR_WIDTH-1:0] IDX_HALT =
    ADDR_WIDTH'(MEM_SIZE_WORDS - CELL_HALT);

  localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(BW);
  localparam logic [ADDR_WIDTH-1:0] ALIGN = ~(STEP - ADDR_WIDTH'(1));

  sig_state_e state_q;

  logic [DATA_WIDTH-1:0] start_q;
  logic [DATA_WIDTH-1:0] end_q;
  logic [DATA_WIDTH-1:0] start_d;
  logic [DATA_WIDTH-1:0] end_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [ADDR_WIDTH-1:0] widx;
  logic [ADDR_WIDTH-1:0] start_a;
  logic [ADDR_WIDTH-1:0] end_a;

  logic fire;
  logic in_run;
  logic hit_start;
  logic hit_end;
  logic halt_go;
  logic last;
  logic expire;

  assign fire = snp_req_valid_i & snp_req_ready_i
              & snp_req_write_i;
  assign widx = snp_req_addr_i >> OFF;

  // Range cells only accept writes while waiting for halt.
  assign in_run    = (state_q == S_RUN);
  assign hit_start = fire & in_run & (widx == IDX_START);
  assign hit_end   = fire & in_run & (widx == IDX_END);
  assign halt_go   = fire & in_run & (widx == IDX_HALT)
                   & (&snp_req_strobe_i)
                   & (snp_req_data_i == DATA_WIDTH'(1));

  assign start_a = ADDR_WIDTH'(start_q);
  assign end_a   = ADDR_WIDTH'(end_q);
  assign last    = (ptr_q >= end_a);

  // Byte-lane merge of snooped writes into the range registers.
  always_comb begin
    start_d = start_q;
    end_d   = end_q;
    for (int i = 0; i < int'(BW); i++) begin
      if (hit_start && snp_req_strobe_i[i])
        start_d[8*i +: 8] = snp_req_data_i[8*i +: 8];
      if (hit_end && snp_req_strobe_i[i])
        end_d[8*i +: 8] = snp_req_data_i[8*i +: 8];
    end
  end

  // Range registers capture the merged bytes.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      start_q <= '0;
      end_q   <= '0;
    end else begin
      start_q <= start_d;
      end_q   <= end_d;
    end
  end

`ifdef JEDRO_1_SIG_MONITOR_TIMEOUT_EN
  localparam logic [31:0] CNT_LAST = 32'(TIMEOUT - 1);

  logic [31:0] cnt_q;
  logic        to_q;

  assign expire    = (cnt_q == CNT_LAST);
  assign timeout_o = to_q;

  // Run-cycle counter; a halt in the expiry cycle still wins.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else if (in_run) begin
      if (!expire)
        cnt_q <= cnt_q + 32'd1;
      if (expire && !halt_go)
        to_q <= 1'b1;
    end
  end
`else
  assign expire    = 1'b0;
  assign timeout_o = 1'b0;

  // The limit only matters with the watchdog compiled in.
  if (TIMEOUT == 0) begin : g_no_limit
  end
`endif

  // Main sequencer: wait for halt, then read and emit one word at a time.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_RUN;
      ptr_q   <= '0;
      data_q  <= '0;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (halt_go) begin
            ptr_q   <= start_a & ALIGN;
            state_q <= (start_a >= end_a) ? S_DONE : S_REQ;
          end else if (expire) begin
            state_q <= S_DONE;
          end
        end
        S_REQ: begin
          if (rd_req_ready_i)
            state_q <= S_RSP;
        end
        S_RSP: begin
          if (rd_rsp_valid_i) begin
            data_q  <= rd_rsp_data_i;
            ptr_q   <= ptr_q + STEP;
            state_q <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (sig_ready_i)
            state_q <= last ? S_DONE : S_REQ;
        end
        S_DONE: begin
          state_q <= S_DONE;
        end
        default: begin
          state_q <= S_RUN;
        end
      endcase
    end
  end

  assign rd_req_valid_o = (state_q == S_REQ);
  assign rd_req_addr_o  = ptr_q;
  assign rd_rsp_ready_o = (state_q == S_RSP);
  assign sig_valid_o    = (state_q == S_EMIT);
  assign sig_last_o     = (state_q == S_EMIT) & last;
  assign sig_data_o     = data_q;
  assign done_o         = (state_q == S_DONE);
  assign busy_o         = (state_q == S_REQ)
                        | (state_q == S_RSP)
                        | (state_q == S_EMIT);

endmodule

// File: tb/tb_jedro_1_sig_monitor.sv
// tb_jedro_1_sig_monitor: directed bench with a range-level stream model.
// Timeout expectations follow JEDRO_1_SIG_MONITOR_TIMEOUT_EN.
module tb_jedro_1_sig_monitor;

  localparam int unsigned MW = 1 << 19;
  localparam logic [31:0] A_START = 32'((MW - 1) * 4);
  localparam logic [31:0] A_END   = 32'((MW - 2) * 4);
  localparam logic [31:0] A_HALT  = 32'((MW - 3) * 4);

  localparam logic [31:0] WA = 32'hA000_000A;
  localparam logic [31:0] WB = 32'hB000_000B;
  localparam logic [31:0] WC = 32'hC000_000C;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic [31:0] snp_req_addr_i = '0;
  logic [31:0] snp_req_data_i = '0;
  logic [3:0]  snp_req_strobe_i = '0;
  logic        snp_req_write_i = 1'b0;
  logic        snp_req_valid_i = 1'b0;
  logic        snp_req_ready_i = 1'b0;
  logic [31:0] rd_req_addr_o;
  logic        rd_req_valid_o;
  logic        rd_req_ready_i = 1'b1;
  logic [31:0] rd_rsp_data_i = '0;
  logic        rd_rsp_valid_i = 1'b0;
  logic        rd_rsp_ready_o;
  logic [31:0] sig_data_o;
  logic        sig_valid_o;
  logic        sig_last_o;
  logic        sig_ready_i = 1'b1;
  logic        busy_o;
  logic        done_o;
  logic        timeout_o;

  jedro_1_sig_monitor #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .MEM_SIZE_WORDS(MW),
    .TIMEOUT(50)
  ) dut (
    .clk_i(clk_i),
    .rstn_i(rstn_i),
    .snp_req_addr_i(snp_req_addr_i),
    .snp_req_data_i(snp_req_data_i),
    .snp_req_strobe_i(snp_req_strobe_i),
    .snp_req_write_i(snp_req_write_i),
    .snp_req_valid_i(snp_req_valid_i),
    .snp_req_ready_i(snp_req_ready_i),
    .rd_req_addr_o(rd_req_addr_o),
    .rd_req_valid_o(rd_req_valid_o),
    .rd_req_ready_i(rd_req_ready_i),
    .rd_rsp_data_i(rd_rsp_data_i),
    .rd_rsp_valid_i(rd_rsp_valid_i),
    .rd_rsp_ready_o(rd_rsp_ready_o),
    .sig_data_o(sig_data_o),
    .sig_valid_o(sig_valid_o),
    .sig_last_o(sig_last_o),
    .sig_ready_i(sig_ready_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_fail = 0;
  int n_req = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_q [$];
  logic [31:0] addr_q [$];
  logic [31:0] got_q [$];

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  // Model: every aligned word from start up to (not incl.) end.
  task automatic expect_run(input logic [31:0] s,
                            input logic [31:0] e);
    logic [31:0] a;
    a = s & ~32'h3;
    while (a < e) begin
      exp_q.push_back(mem_rd(a));
      addr_q.push_back(a);
      a = a + 32'd4;
    end
  endtask

  // Stream compare against the model on every valid cycle.
  always @(negedge clk_i) begin
    if (rstn_i) begin
      if (sig_valid_o) begin
        if (exp_q.size() == 0) begin
          check("sig_unexpected", 64'(sig_valid_o), 64'd0);
        end else begin
          check("sig_data", 64'(sig_data_o), 64'(exp_q[0]));
          check("sig_last", 64'(sig_last_o),
                64'(exp_q.size() == 1));
          if (sig_ready_i) begin
            got_q.push_back(sig_data_o);
            void'(exp_q.pop_front());
          end
        end
      end
      if (busy_o && done_o)
        check("busy_and_done", 64'(busy_o & done_o), 64'd0);
    end
  end

  // Memory responder: one-cycle read latency, checks addresses.
  initial begin : responder
    logic outst;
    logic [31:0] pend;
    outst = 1'b0;
    pend = '0;
    forever begin
      @(negedge clk_i);
      if (!rstn_i) begin
        outst = 1'b0;
        rd_rsp_valid_i = 1'b0;
      end else begin
        if (rd_rsp_ready_o) begin
          rd_rsp_valid_i = 1'b1;
          rd_rsp_data_i = mem_rd(pend);
          outst = 1'b0;
        end else begin
          rd_rsp_valid_i = 1'b0;
        end
        if (rd_req_valid_o) begin
          check("one_outstanding", 64'(outst), 64'd0);
          if (addr_q.size() == 0) begin
            check("rd_req_unexpected", 64'(rd_req_addr_o), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            check("rd_req_addr", 64'(rd_req_addr_o), 64'(addr_q[0]));
            void'(addr_q.pop_front());
          end
          outst = 1'b1;
          pend = rd_req_addr_o;
          n_req++;
        end
      end
    end
  end

  task automatic do_reset();
    rstn_i = 1'b0;
    exp_q.delete();
    addr_q.delete();
    got_q.delete();
    n_req = 0;
    repeat (2) @(posedge clk_i);
    #2;
    rstn_i = 1'b1;
  endtask

  task automatic snoop(input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [3:0] s,
                       input logic w);
    snp_req_addr_i = a;
    snp_req_data_i = d;
    snp_req_strobe_i = s;
    snp_req_write_i = w;
    snp_req_valid_i = 1'b1;
    snp_req_ready_i = 1'b1;
    @(posedge clk_i);
    #2;
    snp_req_valid_i = 1'b0;
    snp_req_ready_i = 1'b0;
    snp_req_write_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    for (int i = 0; i < budget; i++) begin
      if (done_o) break;
      @(posedge clk_i);
      #2;
    end
    check(nm, 64'(done_o), 64'd1);
  endtask

  task automatic wait_valid(input int budget, input string nm);
    for (int i = 0; i < budget; i++) begin
      if (sig_valid_o) break;
      @(posedge clk_i);
      #2;
    end
    check(nm, 64'(sig_valid_o), 64'd1);
  endtask

  task automatic check_idle(input string nm);
    check(nm, 64'({busy_o, done_o, rd_req_valid_o}), 64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cyc;
    logic [31:0] r0;
    mem[32'h100] = WA;
    mem[32'h104] = WB;
    mem[32'h108] = WC;

    // Reset state.
    do_reset();
    check("reset_outputs",
          64'({rd_req_valid_o, rd_rsp_ready_o, sig_valid_o,
               sig_last_o, busy_o, done_o, timeout_o}), 64'd0);
    check("reset_sig_data", 64'(sig_data_o), 64'd0);
    check("reset_rd_addr", 64'(rd_req_addr_o), 64'd0);

    // Three-beat transfer.
    expect_run(32'h100, 32'h10C);
    snoop(A_START, 32'h100, 4'hF, 1'b1);
    snoop(A_END, 32'h10C, 4'hF, 1'b1);
    snoop(A_HALT, 32'h1, 4'hF, 1'b1);
    check("run3_busy", 64'(busy_o), 64'd1);
    wait_done(60, "run3_done");
    check("run3_beats", 64'(got_q.size()), 64'd3);
    if (got_q.size() == 3) begin
      check("run3_a", 64'(got_q[0]), 64'(WA));
      check("run3_b", 64'(got_q[1]), 64'(WB));
      check("run3_c", 64'(got_q[2]), 64'(WC));
    end
    check("run3_reads", 64'(n_req), 64'd3);
    check("run3_done_busy", 64'(busy_o), 64'd0);

    // Stall on beat B.
    do_reset();
    sig_ready_i = 1'b0;
    expect_run(32'h100, 32'h10C);
    snoop(A_START, 32'h100, 4'hF, 1'b1);
    snoop(A_END, 32'h10C, 4'hF, 1'b1);
    snoop(A_HALT, 32'h1, 4'hF, 1'b1);
    wait_valid(20, "stall_a_valid");
    sig_ready_i = 1'b1;
    @(posedge clk_i);
    #2;
    sig_ready_i = 1'b0;
    wait_valid(20, "stall_b_valid");
    r0 = n_req;
    repeat (5) @(posedge clk_i);
    #2;
    check("stall_b_held", 64'(sig_data_o), 64'(WB));
    check("stall_b_valid", 64'(sig_valid_o), 64'd1);
    check("stall_no_req", 64'(n_req), 64'(r0));
    sig_ready_i = 1'b1;
    wait_done(60, "stall_done");
    check("stall_beats", 64'(got_q.size()), 64'd3);
    check("stall_reads", 64'(n_req), 64'd3);

    // Empty range.
    do_reset();
    snoop(A_START, 32'h200, 4'hF, 1'b1);
    snoop(A_END, 32'h200, 4'hF, 1'b1);
    snoop(A_HALT, 32'h1, 4'hF, 1'b1);
    check("empty_done_next", 64'(done_o), 64'd1);
    check("empty_busy", 64'(busy_o), 64'd0);
    repeat (4) @(posedge clk_i);
    #2;
    check("empty_beats", 64'(got_q.size()), 64'd0);
    check("empty_reads", 64'(n_req), 64'd0);

    // Rejected halts, byte merges, unaligned start, late writes.
    do_reset();
    snoop(A_START, 32'hFFFF_0302, 4'b0011, 1'b1);
    snoop(A_START, 32'h0000_FFFF, 4'b1100, 1'b1);
    snoop(A_END, 32'h308, 4'hF, 1'b1);
    snoop(A_HALT, 32'h1, 4'b0001, 1'b1);
    @(posedge clk_i);
    #2;
    check_idle("halt_strobe_idle");
    snoop(A_HALT, 32'h2, 4'hF, 1'b1);
    @(posedge clk_i);
    #2;
    check_idle("halt_data2_idle");
    snoop(A_HALT, 32'h1, 4'hF, 1'b0);
    @(posedge clk_i);
    #2;
    check_idle("halt_read_idle");
    expect_run(32'h302, 32'h308);
    snoop(A_HALT, 32'h1, 4'hF, 1'b1);
    check("halt_ok_busy", 64'(busy_o), 64'd1);
    snoop(A_END, 32'h1000, 4'hF, 1'b1);
    wait_done(60, "merge_done");
    check("merge_beats", 64'(got_q.size()), 64'd2);
    if (got_q.size() == 2)
      check("merge_first", 64'(got_q[0]), 64'(32'h300 ^ 32'h5A5A_0000));
    check("merge_reads", 64'(n_req), 64'd2);

    // Asynchronous reset during beat 2.
    do_reset();
    sig_ready_i = 1'b0;
    expect_run(32'h100, 32'h10C);
    snoop(A_START, 32'h100, 4'hF, 1'b1);
    snoop(A_END, 32'h10C, 4'hF, 1'b1);
    snoop(A_HALT, 32'h1, 4'hF, 1'b1);
    wait_valid(20, "rst_a_valid");
    sig_ready_i = 1'b1;
    @(posedge clk_i);
    #2;
    sig_ready_i = 1'b0;
    wait_valid(20, "rst_b_valid");
    #1;
    rstn_i = 1'b0;
    #1;
    check("rst_async_outputs",
          64'({rd_req_valid_o, rd_rsp_ready_o, sig_valid_o,
               sig_last_o, busy_o, done_o, timeout_o}), 64'd0);
    check("rst_async_data", 64'(sig_data_o), 64'd0);
    sig_ready_i = 1'b1;
    do_reset();
    check_idle("rst_run_idle");
    expect_run(32'h100, 32'h108);
    snoop(A_START, 32'h100, 4'hF, 1'b1);
    snoop(A_END, 32'h108, 4'hF, 1'b1);
    snoop(A_HALT, 32'h1, 4'hF, 1'b1);
    wait_done(60, "rst_rerun_done");
    check("rst_rerun_beats", 64'(got_q.size()), 64'd2);

    // Watchdog behaviour.
    do_reset();
    cyc = 0;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk_i);
      #1;
      cyc = i;
      if (done_o) break;
    end
`ifdef JEDRO_1_SIG_MONITOR_TIMEOUT_EN
    check("to_cycle", 64'(cyc), 64'd50);
    check("to_flags", 64'({timeout_o, done_o, busy_o}), 64'b110);
    check("to_beats", 64'(got_q.size()), 64'd0);
    do_reset();
    expect_run(32'h400, 32'h404);
    snoop(A_START, 32'h400, 4'hF, 1'b1);
    snoop(A_END, 32'h404, 4'hF, 1'b1);
    repeat (47) @(posedge clk_i);
    #2;
    snoop(A_HALT, 32'h1, 4'hF, 1'b1);
    check("to_halt_wins", 64'({timeout_o, busy_o}), 64'b01);
    wait_done(60, "to_halt_done");
    check("to_halt_beats", 64'(got_q.size()), 64'd1);
    check("to_halt_flag", 64'(timeout_o), 64'd0);
`else
    check("no_to_cycle", 64'(cyc), 64'd80);
    check("no_to_flags", 64'({timeout_o, done_o, busy_o}), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
